// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-to-UART drain block.
package fifo_uart_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: free-runs while clr is low and pulses tick on the last
// cycle of each CLKS_PER_BIT period.
module uart_baud_tick
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int                CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_comb begin
    tick = (cnt == LAST);
  end

  always_ff @(posedge clk) begin
    if (rst || clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_drain.sv
// Pops bytes from the byte FIFO and serialises each as an 8N1 UART frame.
// A FIFO read rejected by a simultaneous write is retried from FETCH.
module fifo_uart_drain
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_W       = UART_DATA_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic              fifo_full,
  input  logic              fifo_we,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_re,
  output logic              tx,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  localparam int               IDX_W    = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_W - 1);

  state_t            state, state_d;
  logic [DATA_W-1:0] shreg, shreg_d;
  logic [IDX_W-1:0]  bit_idx, bit_idx_d;
  logic [15:0]       frame_cnt_d;
  logic              tx_d, fifo_re_d, busy_d;
  logic              baud_clr, baud_tick;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (baud_clr),
    .tick (baud_tick)
  );

  always_comb begin
    state_d     = state;
    shreg_d     = shreg;
    bit_idx_d   = bit_idx;
    frame_cnt_d = frame_cnt;
    baud_clr    = 1'b1;

    unique case (state)
      IDLE: begin
        if (en && !fifo_empty) state_d = FETCH;
      end
      FETCH: begin
        // A write accepted in the same cycle means the FIFO ignored our read.
        if (!(fifo_we && !fifo_full)) state_d = LOAD;
      end
      LOAD: begin
        shreg_d = fifo_dout;
        state_d = START;
      end
      START: begin
        baud_clr = 1'b0;
        if (baud_tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        baud_clr = 1'b0;
        if (baud_tick) begin
          if (bit_idx == LAST_BIT) begin
            state_d = STOP;
          end else begin
            shreg_d   = {1'b0, shreg[DATA_W-1:1]};
            bit_idx_d = bit_idx + 1'b1;
          end
        end
      end
      STOP: begin
        baud_clr = 1'b0;
        if (baud_tick) begin
          frame_cnt_d = frame_cnt + 16'd1;
          state_d     = (en && !fifo_empty) ? FETCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs decode the next state so the registered copies line up with it.
    tx_d = 1'b1;
    if (state_d == START) begin
      tx_d = 1'b0;
    end else if (state_d == DATA) begin
      tx_d = shreg_d[0];
    end
    fifo_re_d = (state_d == FETCH);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_idx   <= '0;
      frame_cnt <= '0;
      tx        <= 1'b1;
      fifo_re   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      shreg     <= shreg_d;
      bit_idx   <= bit_idx_d;
      frame_cnt <= frame_cnt_d;
      tx        <= tx_d;
      fifo_re   <= fifo_re_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Bench for fifo_uart_drain: behavioural FIFO, UART line decoder and a byte
// scoreboard, driven by directed scenarios followed by random traffic.
module tb_fifo_uart_drain;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst, en, fifo_we, fifo_re, tx, busy;
  logic        fifo_empty, fifo_full, we_acc, re_acc;
  logic [7:0]  fifo_dout = 8'h00;
  logic [7:0]  fifo_wdata;
  logic [15:0] frame_cnt;
  logic [15:0] exp_frames = 16'h0;
  int          fcount = 0;
  logic [7:0]  fq[$];
  logic [7:0]  exp_q[$];
  int          n_cmp = 0, n_fail = 0;
  int          frames_done = 0, last_gap = 0, re_pulses = 0;

  always #5 clk = ~clk;

  fifo_uart_drain #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .fifo_empty(fifo_empty),
    .fifo_full (fifo_full),
    .fifo_we   (fifo_we),
    .fifo_dout (fifo_dout),
    .fifo_re   (fifo_re),
    .tx        (tx),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  // 16-deep FIFO with registered read data; a write wins over a read.
  assign fifo_empty = (fcount == 0);
  assign fifo_full  = (fcount == DEPTH);
  assign we_acc     = fifo_we && !fifo_full;
  assign re_acc     = fifo_re && !fifo_empty && !we_acc;

  always @(posedge clk) begin
    if (we_acc) fq.push_back(fifo_wdata);
    if (re_acc) fifo_dout <= fq.pop_front();
    fcount <= fcount + int'(we_acc) - int'(re_acc);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic write_cycle(input logic [7:0] b);
    fifo_we    = 1'b1;
    fifo_wdata = b;
    if (fcount < DEPTH) exp_q.push_back(b);
    @(negedge clk);
    fifo_we = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int target;
    int t;
    target = frames_done + n;
    t = 0;
    while (frames_done < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("wait_frames", 32'(frames_done), 32'(target));
  endtask

  task automatic wait_tx_low(input int budget);
    int t;
    t = 0;
    while (tx !== 1'b0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("wait_tx_low", 32'(tx), 32'(0));
  endtask

  // Line decoder: samples tx once per cycle and rebuilds each frame.
  initial begin : monitor
    logic [FRAME-1:0] line;
    logic [7:0]       got;
    bit               shape_ok, aborted;
    int               high_run;
    high_run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        high_run = 0;
        continue;
      end
      if (tx === 1'b1) begin
        high_run++;
        continue;
      end
      last_gap = high_run;
      high_run = 0;
      line     = '0;
      line[0]  = tx;
      aborted  = 1'b0;
      for (int k = 1; k < FRAME; k++) begin
        @(negedge clk);
        if (rst) begin
          aborted = 1'b1;
          break;
        end
        line[k] = tx;
      end
      if (aborted) continue;
      shape_ok = 1'b1;
      for (int b = 0; b < 10; b++)
        for (int s = 1; s < CPB; s++)
          if (line[b*CPB+s] !== line[b*CPB]) shape_ok = 1'b0;
      if (line[0] !== 1'b0 || line[9*CPB] !== 1'b1) shape_ok = 1'b0;
      for (int i = 0; i < 8; i++) got[i] = line[(i+1)*CPB];
      check("frame_shape", 32'(shape_ok), 32'(1));
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL frame_unexpected: got byte 0x%0h, expected no frame", got);
      end else begin
        check("frame_byte", 32'(got), 32'(exp_q.pop_front()));
      end
      exp_frames++;
      @(negedge clk);
      high_run = (tx === 1'b1) ? 1 : 0;
      if (!rst) check("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
      frames_done++;
    end
  end

  initial begin : re_watch
    logic re_prev;
    re_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (fifo_re === 1'b1) begin
        if (!re_prev) re_pulses++;
        check("re_while_empty", 32'(fifo_empty), 32'(0));
      end
      re_prev = fifo_re;
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int p0, bad, t;
    rst = 1'b1; en = 1'b0; fifo_we = 1'b0; fifo_wdata = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_re", 32'(fifo_re), 32'(0));
    check("rst_frame_cnt", 32'(frame_cnt), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // Single byte
    write_cycle(8'hA5);
    p0 = re_pulses;
    en = 1'b1;
    wait_frames(1, 100);
    check("single_re_pulses", 32'(re_pulses - p0), 32'(1));
    check("single_busy_after", 32'(busy), 32'(0));
    check("single_tx_after", 32'(tx), 32'(1));
    check("single_fifo_empty", 32'(fcount), 32'(0));

    // Back-to-back
    en = 1'b0;
    write_cycle(8'h01);
    write_cycle(8'hFF);
    p0 = re_pulses;
    en = 1'b1;
    wait_frames(2, 200);
    check("b2b_gap", 32'(last_gap), 32'(2));
    check("b2b_re_pulses", 32'(re_pulses - p0), 32'(2));
    check("b2b_fifo_empty", 32'(fcount), 32'(0));
    check("b2b_frame_cnt", 32'(frame_cnt), 32'(3));

    // Read collision on the first FETCH cycle
    en = 1'b0;
    write_cycle(8'h11);
    p0 = re_pulses;
    en = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (fifo_re !== 1'b1 && t < 10);
    check("collide_re_seen", 32'(fifo_re), 32'(1));
    fifo_we    = 1'b1;
    fifo_wdata = 8'h22;
    if (fcount < DEPTH) exp_q.push_back(8'h22);
    @(negedge clk);
    fifo_we = 1'b0;
    check("collide_re_hold", 32'(fifo_re), 32'(1));
    @(negedge clk);
    check("collide_re_drop", 32'(fifo_re), 32'(0));
    wait_frames(2, 200);
    check("collide_re_pulses", 32'(re_pulses - p0), 32'(2));
    check("collide_fifo_empty", 32'(fcount), 32'(0));

    // Empty FIFO with en high, then a queued byte with en low
    p0 = re_pulses; bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    en = 1'b0;
    write_cycle(8'h3C);
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("idle_line_quiet", 32'(bad), 32'(0));
    check("idle_no_re", 32'(re_pulses - p0), 32'(0));
    check("idle_byte_kept", 32'(fcount), 32'(1));
    en = 1'b1;
    wait_frames(1, 100);

    // en dropped mid-frame with a second byte queued
    en = 1'b0;
    write_cycle(8'h55);
    write_cycle(8'h66);
    p0 = re_pulses;
    en = 1'b1;
    wait_tx_low(20);
    repeat (10) @(negedge clk);
    en = 1'b0;
    wait_frames(1, 100);
    repeat (30) @(negedge clk);
    check("endrop_re_pulses", 32'(re_pulses - p0), 32'(1));
    check("endrop_byte_kept", 32'(fcount), 32'(1));
    check("endrop_busy", 32'(busy), 32'(0));

    // Reset during bit 3 of 0xC3 (0x66 goes out first)
    write_cycle(8'hC3);
    write_cycle(8'h5A);
    en = 1'b1;
    wait_frames(1, 100);
    wait_tx_low(10);
    repeat (CPB + 3*CPB + 1) @(negedge clk);
    rst = 1'b1;
    void'(exp_q.pop_front());
    exp_frames = 16'h0;
    @(negedge clk);
    check("midrst_tx", 32'(tx), 32'(1));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_frame_cnt", 32'(frame_cnt), 32'(0));
    check("midrst_re", 32'(fifo_re), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_frames(1, 100);
    check("midrst_fifo_empty", 32'(fcount), 32'(0));

    // Random traffic with en toggling; FIFO fills and runs full
    en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 3) == 0) begin
        fifo_wdata = 8'($urandom);
        fifo_we    = 1'b1;
        if (fcount < DEPTH) exp_q.push_back(fifo_wdata);
      end else begin
        fifo_we = 1'b0;
      end
      @(negedge clk);
    end
    fifo_we = 1'b0;
    en      = 1'b1;
    t = 0;
    while ((exp_q.size() != 0 || busy === 1'b1 || fcount != 0) && t < 8000) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    check("drain_exp_empty", 32'(exp_q.size()), 32'(0));
    check("drain_fifo_empty", 32'(fcount), 32'(0));
    check("drain_idle", 32'(busy), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
